// File: rtl/safety_sequencer_if.sv
// Handshake bundle between the safety sequencer and its trip sources, the
// ground-fault self-test engine and the operator clear path.
interface safety_sequencer_if;
    logic       enable;
    logic       ov_tripped;
    logic       gf_trip;
    logic       update_busy;
    logic       clear_req;
    logic       st_done;
    logic       st_pass;
    logic       st_start;
    logic       ov_clear;
    logic       gf_clear;
    logic [2:0] state;
    logic       safe_ok;
    logic       lockout;
    logic [3:0] fault_code;
    logic [7:0] trip_count;
    logic [7:0] retry_cnt;

    modport master (
        output enable, ov_tripped, gf_trip, update_busy, clear_req, st_done, st_pass,
        input  st_start, ov_clear, gf_clear, state, safe_ok, lockout,
               fault_code, trip_count, retry_cnt
    );

    modport slave (
        input  enable, ov_tripped, gf_trip, update_busy, clear_req, st_done, st_pass,
        output st_start, ov_clear, gf_clear, state, safe_ok, lockout,
               fault_code, trip_count, retry_cnt
    );
endinterface

// File: rtl/safety_sequencer.sv
// Trip/clear/self-test supervisor: schedules periodic GFDI self-tests, latches
// trips, runs held-off clear attempts and locks out after repeated failures.
module safety_sequencer #(
    parameter logic [31:0] SELFTEST_PERIOD  = 32'd500_000_000,
    parameter logic [31:0] SELFTEST_TIMEOUT = 32'd50_000,
    parameter logic [31:0] CLEAR_HOLDOFF    = 32'd5_000_000,
    parameter logic [7:0]  MAX_RETRIES      = 8'd3
) (
    input logic              clk,
    input logic              rst_n,
    safety_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_RUN      = 3'd0,
        S_SELFTEST = 3'd1,
        S_TRIPPED  = 3'd2,
        S_HOLDOFF  = 3'd3,
        S_CLEARING = 3'd4,
        S_LOCKOUT  = 3'd5
    } state_t;

    state_t      state_q, state_n;
    logic [31:0] period_q, period_n;
    logic [31:0] timer_q, timer_n;
    logic [3:0]  code_q, code_n;
    logic [7:0]  trips_q, trips_n;
    logic [7:0]  retry_q, retry_n;
    logic        st_start_q, st_start_n;
    logic        ov_clear_q, ov_clear_n;
    logic        gf_clear_q, gf_clear_n;
    logic        safe_ok_q, safe_ok_n;
    logic        lockout_q, lockout_n;

    logic        trip_now;
    logic [3:0]  trip_code;
    logic        do_trip;
    logic [3:0]  trip_src;
    logic [7:0]  trip_retry;

    assign trip_now  = bus.ov_tripped | bus.gf_trip;
    assign trip_code = {2'b00, bus.gf_trip, bus.ov_tripped};

    // NOTE: every always_comb output gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_n    = state_q;
        period_n   = period_q;
        timer_n    = timer_q;
        code_n     = code_q;
        trips_n    = trips_q;
        retry_n    = retry_q;
        st_start_n = 1'b0;
        ov_clear_n = 1'b0;
        gf_clear_n = 1'b0;
        do_trip    = 1'b0;
        trip_src   = 4'd0;
        trip_retry = retry_q;

        unique case (state_q)
            S_RUN: begin
                if (trip_now) begin
                    do_trip  = 1'b1;
                    trip_src = trip_code;
                end else if (bus.enable) begin
                    if (period_q == SELFTEST_PERIOD - 32'd1) begin
                        // Terminal count is held while an update is in progress.
                        if (!bus.update_busy) begin
                            state_n    = S_SELFTEST;
                            st_start_n = 1'b1;
                            period_n   = 32'd0;
                            timer_n    = 32'd0;
                        end
                    end else begin
                        period_n = period_q + 32'd1;
                    end
                end
            end

            S_SELFTEST: begin
                // The self-test injects a ground fault, so only overvoltage trips here.
                if (bus.ov_tripped) begin
                    do_trip  = 1'b1;
                    trip_src = 4'd1;
                end else if (bus.st_done) begin
                    if (bus.st_pass) begin
                        state_n    = S_RUN;
                        gf_clear_n = 1'b1;
                        retry_n    = 8'd0;
                    end else begin
                        state_n = S_LOCKOUT;
                        code_n  = 4'd4;
                    end
                end else if (timer_q == SELFTEST_TIMEOUT - 32'd1) begin
                    state_n = S_LOCKOUT;
                    code_n  = 4'd5;
                end else begin
                    timer_n = timer_q + 32'd1;
                end
            end

            S_TRIPPED: begin
                if (bus.clear_req) begin
                    state_n = S_HOLDOFF;
                    timer_n = 32'd0;
                end
            end

            S_HOLDOFF: begin
                code_n = code_q | trip_code;
                if (timer_q == CLEAR_HOLDOFF - 32'd1) begin
                    state_n    = S_CLEARING;
                    timer_n    = 32'd0;
                    ov_clear_n = code_n[0];
                    gf_clear_n = code_n[1];
                end else begin
                    timer_n = timer_q + 32'd1;
                end
            end

            S_CLEARING: begin
                if (timer_q == 32'd0) begin
                    timer_n = 32'd1;
                end else if (trip_now) begin
                    do_trip    = 1'b1;
                    trip_src   = trip_code;
                    trip_retry = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
                end else begin
                    state_n = S_RUN;
                    code_n  = 4'd0;
                end
            end

            S_LOCKOUT: begin
            end

            default: state_n = S_RUN;
        endcase

        // Common entry into TRIPPED; exhausted retries divert to LOCKOUT.
        if (do_trip) begin
            trips_n = (trips_q == 8'hFF) ? trips_q : trips_q + 8'd1;
            retry_n = trip_retry;
            if (trip_retry == MAX_RETRIES) begin
                state_n = S_LOCKOUT;
                code_n  = 4'd6;
            end else begin
                state_n = S_TRIPPED;
                code_n  = trip_src;
            end
        end

        safe_ok_n = (state_n == S_RUN) || (state_n == S_SELFTEST);
        lockout_n = (state_n == S_LOCKOUT);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            period_q   <= 32'd0;
            timer_q    <= 32'd0;
            code_q     <= 4'd0;
            trips_q    <= 8'd0;
            retry_q    <= 8'd0;
            st_start_q <= 1'b0;
            ov_clear_q <= 1'b0;
            gf_clear_q <= 1'b0;
            safe_ok_q  <= 1'b0;
            lockout_q  <= 1'b0;
        end else begin
            state_q    <= state_n;
            period_q   <= period_n;
            timer_q    <= timer_n;
            code_q     <= code_n;
            trips_q    <= trips_n;
            retry_q    <= retry_n;
            st_start_q <= st_start_n;
            ov_clear_q <= ov_clear_n;
            gf_clear_q <= gf_clear_n;
            safe_ok_q  <= safe_ok_n;
            lockout_q  <= lockout_n;
        end
    end

    assign bus.state      = state_q;
    assign bus.fault_code = code_q;
    assign bus.trip_count = trips_q;
    assign bus.retry_cnt  = retry_q;
    assign bus.st_start   = st_start_q;
    assign bus.ov_clear   = ov_clear_q;
    assign bus.gf_clear   = gf_clear_q;
    assign bus.safe_ok    = safe_ok_q;
    assign bus.lockout    = lockout_q;

endmodule

// File: tb/tb_safety_sequencer.sv
// Directed bench for safety_sequencer with short timing parameters
// (period 100, self-test timeout 20, clear hold-off 10, max retries 2).
module tb_safety_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   overlap = 0;

    safety_sequencer_if bus();

    safety_sequencer #(
        .SELFTEST_PERIOD (32'd100),
        .SELFTEST_TIMEOUT(32'd20),
        .CLEAR_HOLDOFF   (32'd10),
        .MAX_RETRIES     (8'd2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Outputs are sampled on the falling edge, half a cycle after they update.
    always @(negedge clk) begin
        if (rst_n && bus.st_start && (bus.ov_clear || bus.gf_clear)) overlap++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.enable = 1'b0; bus.ov_tripped = 1'b0; bus.gf_trip = 1'b0;
        bus.update_busy = 1'b0; bus.clear_req = 1'b0;
        bus.st_done = 1'b0; bus.st_pass = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick(2);
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.state); end
        checks++; if (bus.safe_ok !== 1'b0) begin errors++; $display("FAIL reset_safe_ok got %b exp 0", bus.safe_ok); end
        checks++; if (bus.lockout !== 1'b0) begin errors++; $display("FAIL reset_lockout got %b exp 0", bus.lockout); end
        checks++; if ({bus.fault_code, bus.trip_count, bus.retry_cnt} !== 20'd0) begin errors++; $display("FAIL reset_counters got code %0d trips %0d retry %0d exp 0", bus.fault_code, bus.trip_count, bus.retry_cnt); end
        checks++; if ({bus.st_start, bus.ov_clear, bus.gf_clear} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {bus.st_start, bus.ov_clear, bus.gf_clear}); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.safe_ok !== 1'b1) begin errors++; $display("FAIL release_safe_ok got %b exp 1", bus.safe_ok); end
    endtask

    task automatic test_selftest_pass();
        int seen = 0;
        do_reset();
        bus.enable = 1'b1;
        repeat (99) begin tick(); if (bus.st_start === 1'b1) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL st_start_early got %0d pulses exp 0", seen); end
        tick();
        checks++; if ({bus.st_start, bus.state} !== {1'b1, 3'd1}) begin errors++; $display("FAIL st_start_at_100 got start %b state %0d exp 1/1", bus.st_start, bus.state); end
        tick();
        checks++; if (bus.st_start !== 1'b0) begin errors++; $display("FAIL st_start_width got %b exp 0", bus.st_start); end
        bus.gf_trip = 1'b1;
        tick(2);
        checks++; if ({bus.state, bus.trip_count} !== {3'd1, 8'd0}) begin errors++; $display("FAIL gf_in_selftest got state %0d trips %0d exp 1/0", bus.state, bus.trip_count); end
        bus.gf_trip = 1'b0;
        tick();
        bus.st_done = 1'b1; bus.st_pass = 1'b1;
        tick();
        checks++; if ({bus.gf_clear, bus.state, bus.safe_ok} !== {1'b1, 3'd0, 1'b1}) begin errors++; $display("FAIL st_pass got gf_clear %b state %0d safe_ok %b exp 1/0/1", bus.gf_clear, bus.state, bus.safe_ok); end
        bus.st_done = 1'b0; bus.st_pass = 1'b0; bus.enable = 1'b0;
        tick();
        checks++; if (bus.gf_clear !== 1'b0) begin errors++; $display("FAIL gf_clear_width got %b exp 0", bus.gf_clear); end
    endtask

    task automatic test_ov_clear();
        int seen = 0;
        do_reset();
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL clear_in_run got state %0d exp 0", bus.state); end
        bus.ov_tripped = 1'b1;
        tick();
        checks++; if ({bus.state, bus.fault_code, bus.trip_count, bus.safe_ok} !== {3'd2, 4'd1, 8'd1, 1'b0}) begin errors++; $display("FAIL ov_trip got state %0d code %0d trips %0d safe_ok %b exp 2/1/1/0", bus.state, bus.fault_code, bus.trip_count, bus.safe_ok); end
        bus.ov_tripped = 1'b0;
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL holdoff_entry got state %0d exp 3", bus.state); end
        repeat (9) begin tick(); if (bus.ov_clear !== 1'b0 || bus.state !== 3'd3) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL holdoff_early got %0d bad cycles exp 0", seen); end
        tick();
        checks++; if ({bus.ov_clear, bus.gf_clear, bus.state} !== {1'b1, 1'b0, 3'd4}) begin errors++; $display("FAIL ov_clear_at_10 got ov %b gf %b state %0d exp 1/0/4", bus.ov_clear, bus.gf_clear, bus.state); end
        tick();
        checks++; if ({bus.ov_clear, bus.state} !== {1'b0, 3'd4}) begin errors++; $display("FAIL verify_cycle1 got ov %b state %0d exp 0/4", bus.ov_clear, bus.state); end
        tick();
        checks++; if ({bus.state, bus.fault_code, bus.safe_ok} !== {3'd0, 4'd0, 1'b1}) begin errors++; $display("FAIL clear_to_run got state %0d code %0d safe_ok %b exp 0/0/1", bus.state, bus.fault_code, bus.safe_ok); end
    endtask

    task automatic test_dual_trip();
        do_reset();
        bus.ov_tripped = 1'b1; bus.gf_trip = 1'b1;
        tick();
        checks++; if ({bus.state, bus.fault_code} !== {3'd2, 4'd3}) begin errors++; $display("FAIL dual_trip got state %0d code %0d exp 2/3", bus.state, bus.fault_code); end
        bus.ov_tripped = 1'b0; bus.gf_trip = 1'b0;
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        tick(10);
        checks++; if ({bus.ov_clear, bus.gf_clear, bus.st_start} !== 3'b110) begin errors++; $display("FAIL dual_clear got ov %b gf %b st %b exp 1/1/0", bus.ov_clear, bus.gf_clear, bus.st_start); end
        tick(2);
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL dual_to_run got state %0d exp 0", bus.state); end
    endtask

    task automatic test_holdoff_new_trip();
        do_reset();
        bus.ov_tripped = 1'b1;
        tick();
        bus.ov_tripped = 1'b0;
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        tick(3);
        bus.gf_trip = 1'b1;
        tick();
        bus.gf_trip = 1'b0;
        checks++; if ({bus.state, bus.fault_code, bus.trip_count} !== {3'd3, 4'd3, 8'd1}) begin errors++; $display("FAIL holdoff_or got state %0d code %0d trips %0d exp 3/3/1", bus.state, bus.fault_code, bus.trip_count); end
        tick(6);
        checks++; if ({bus.ov_clear, bus.gf_clear, bus.state} !== {1'b1, 1'b1, 3'd4}) begin errors++; $display("FAIL holdoff_or_clear got ov %b gf %b state %0d exp 1/1/4", bus.ov_clear, bus.gf_clear, bus.state); end
        tick(2);
        checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL holdoff_or_run got state %0d exp 0", bus.state); end
    endtask

    task automatic test_retry_lockout();
        int seen = 0;
        do_reset();
        bus.ov_tripped = 1'b1;
        tick();
        checks++; if ({bus.state, bus.trip_count, bus.retry_cnt} !== {3'd2, 8'd1, 8'd0}) begin errors++; $display("FAIL retry_first got state %0d trips %0d retry %0d exp 2/1/0", bus.state, bus.trip_count, bus.retry_cnt); end
        for (int a = 1; a <= 2; a++) begin
            bus.clear_req = 1'b1;
            tick();
            bus.clear_req = 1'b0;
            tick(12);
            if (a == 1) begin
                checks++; if ({bus.state, bus.retry_cnt, bus.trip_count, bus.fault_code} !== {3'd2, 8'd1, 8'd2, 4'd1}) begin errors++; $display("FAIL retry_1 got state %0d retry %0d trips %0d code %0d exp 2/1/2/1", bus.state, bus.retry_cnt, bus.trip_count, bus.fault_code); end
            end else begin
                checks++; if ({bus.state, bus.fault_code, bus.retry_cnt, bus.trip_count} !== {3'd5, 4'd6, 8'd2, 8'd3}) begin errors++; $display("FAIL retry_lockout got state %0d code %0d retry %0d trips %0d exp 5/6/2/3", bus.state, bus.fault_code, bus.retry_cnt, bus.trip_count); end
                checks++; if ({bus.lockout, bus.safe_ok} !== 2'b10) begin errors++; $display("FAIL lockout_flags got lockout %b safe_ok %b exp 1/0", bus.lockout, bus.safe_ok); end
            end
        end
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        repeat (12) begin tick(); if (bus.ov_clear || bus.gf_clear || bus.state !== 3'd5) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL lockout_absorbing got %0d bad cycles exp 0", seen); end
        bus.ov_tripped = 1'b0;
        rst_n = 1'b0;
        tick();
        checks++; if ({bus.state, bus.lockout, bus.fault_code, bus.trip_count, bus.retry_cnt} !== 24'd0) begin errors++; $display("FAIL lockout_reset got state %0d lockout %b code %0d trips %0d retry %0d exp 0", bus.state, bus.lockout, bus.fault_code, bus.trip_count, bus.retry_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_update_busy();
        int first = 0;
        do_reset();
        bus.enable = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            bus.update_busy = (n >= 50 && n <= 180);
            tick();
            if (bus.st_start === 1'b1 && first == 0) first = n;
        end
        bus.update_busy = 1'b0;
        checks++; if (first !== 181) begin errors++; $display("FAIL busy_defer got st_start at %0d exp 181", first); end
    endtask

    task automatic test_timeout();
        int seen = 0;
        do_reset();
        bus.enable = 1'b1;
        tick(100);
        checks++; if (bus.st_start !== 1'b1) begin errors++; $display("FAIL to_st_start got %b exp 1", bus.st_start); end
        repeat (19) begin tick(); if (bus.state !== 3'd1) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL to_early got %0d bad cycles exp 0", seen); end
        tick();
        checks++; if ({bus.state, bus.fault_code, bus.lockout} !== {3'd5, 4'd5, 1'b1}) begin errors++; $display("FAIL to_lockout got state %0d code %0d lockout %b exp 5/5/1", bus.state, bus.fault_code, bus.lockout); end
        seen = 0;
        repeat (150) begin tick(); if (bus.st_start || bus.ov_clear || bus.gf_clear) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL lockout_no_pulse got %0d pulses exp 0", seen); end
    endtask

    task automatic test_selftest_fail();
        do_reset();
        bus.enable = 1'b1;
        tick(100);
        bus.st_done = 1'b1; bus.st_pass = 1'b0;
        tick();
        bus.st_done = 1'b0;
        checks++; if ({bus.state, bus.fault_code} !== {3'd5, 4'd4}) begin errors++; $display("FAIL st_fail got state %0d code %0d exp 5/4", bus.state, bus.fault_code); end
    endtask

    task automatic test_done_at_timeout();
        do_reset();
        bus.enable = 1'b1;
        tick(100);
        tick(19);
        bus.st_done = 1'b1; bus.st_pass = 1'b1;
        tick();
        bus.st_done = 1'b0; bus.st_pass = 1'b0; bus.enable = 1'b0;
        checks++; if ({bus.state, bus.gf_clear} !== {3'd0, 1'b1}) begin errors++; $display("FAIL done_on_timeout got state %0d gf_clear %b exp 0/1", bus.state, bus.gf_clear); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_selftest_pass();
        test_ov_clear();
        test_dual_trip();
        test_holdoff_new_trip();
        test_retry_lockout();
        test_update_busy();
        test_timeout();
        test_selftest_fail();
        test_done_at_timeout();
        checks++; if (overlap !== 0) begin errors++; $display("FAIL pulse_overlap got %0d cycles exp 0", overlap); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
